// File: rtl/pipe_pal_rsp.sv
// pipe_pal responder: services single-beat read/write requests against a
// bank of DEPTH registers and returns in-order responses through a 2-entry
// response buffer, so initiator backpressure does not stall acceptance at once.
module pipe_pal_rsp #(
   parameter int W_DATA = 32,
   parameter int W_ADDR = 16,
   parameter int DEPTH  = 16
) (
   input  logic              i_clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [W_ADDR-1:0] req_addr,
   input  logic [W_DATA-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W_DATA-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        rsp_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**W_ADDR is representable in the compare.
   localparam logic [W_ADDR:0] DEPTH_L = (W_ADDR + 1)'(DEPTH);

   logic [W_DATA-1:0] regs_q [DEPTH];

   logic [W_DATA-1:0] data_q [2];
   logic              err_q  [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   logic              push, pop;
   logic              addr_ok;
   logic              wr_en;
   logic [IDX_W-1:0]  idx;
   logic [W_DATA-1:0] new_rdata;

   // A full buffer can still take a request when its head leaves this cycle.
   assign req_ready = (count_q != 2'd2) || rsp_ready;
   assign push      = req_valid && req_ready;
   assign pop       = (count_q != 2'd0) && rsp_ready;
   assign addr_ok   = ({1'b0, req_addr} < DEPTH_L);
   assign idx       = req_addr[IDX_W-1:0];
   assign wr_en     = push && req_we && addr_ok;

   // Response payload for the request being accepted; reads see pre-edge contents.
   always_comb begin
      new_rdata = '0;
      if (!req_we && addr_ok) begin
         new_rdata = regs_q[idx];
      end
   end

   // Buffer occupancy and pointer bookkeeping.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!push && pop) begin
         count_d = count_q - 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         // Each register loads on an accepted in-range write to its index.
         always_ff @(posedge i_clk or negedge resetn) begin
            if (!resetn) begin
               regs_q[gi] <= '0;
            end else if (wr_en && (idx == IDX_W'(gi))) begin
               regs_q[gi] <= req_wdata;
            end
         end
      end
   endgenerate

   // Response FIFO storage and state; reset discards anything buffered.
   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         err_q[0]  <= 1'b0;
         err_q[1]  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= new_rdata;
            err_q[wr_ptr_q]  <= !addr_ok;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rsp_valid = (count_q != 2'd0);
   assign rsp_rdata = rsp_valid ? data_q[rd_ptr_q] : '0;
   assign rsp_err   = rsp_valid ? err_q[rd_ptr_q] : 1'b0;
   assign rsp_count = count_q;

endmodule

// File: tb/tb_pipe_pal_rsp.sv
// Directed and randomized bench for pipe_pal_rsp (DEPTH=16).
module tb_pipe_pal_rsp;

   logic        i_clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   vec_t        vecs[$];
   rsp_t        sbq[$];
   logic [31:0] mregs [16];

   pipe_pal_rsp #(.W_DATA(32), .W_ADDR(16), .DEPTH(16)) dut (
      .i_clk     (i_clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .rsp_count (rsp_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic next();
      @(posedge i_clk);
      #1;
   endtask

   function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   initial begin
      logic        exp_ready;
      rsp_t        r;
      int          accepted;
      int          cycles;

      // ---- vector table, expected values worked out by hand ----
      vecs.push_back(mk(1'b1, 16'd3, 32'hDEADBEEF, 32'h0, 1'b0));
      vecs.push_back(mk(1'b0, 16'd3, 32'h0, 32'hDEADBEEF, 1'b0));
      for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b1, 16'(i), 32'h100 + 32'(i), 32'h0, 1'b0));
      for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b0, 16'(i), 32'h0, 32'h100 + 32'(i), 1'b0));
      vecs.push_back(mk(1'b0, 16'd16, 32'h0, 32'h0, 1'b1));
      vecs.push_back(mk(1'b1, 16'hFFFF, 32'hCAFEF00D, 32'h0, 1'b1));
      for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b0, 16'(i), 32'h0, 32'h100 + 32'(i), 1'b0));

      // ---- reset ----
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      #3;
      check("reset_valid", 32'(rsp_valid), 32'd0);
      check("reset_count", 32'(rsp_count), 32'd0);
      check("reset_rdata", rsp_rdata, 32'd0);
      check("reset_err",   32'(rsp_err), 32'd0);
      #9 resetn = 1'b1;
      next();
      check("reset_ready", 32'(req_ready), 32'd1);

      // ---- table: back-to-back requests, rsp_ready held high ----
      rsp_ready = 1'b1;
      foreach (vecs[k]) begin
         req_valid = 1'b1;
         req_we    = vecs[k].we;
         req_addr  = vecs[k].addr;
         req_wdata = vecs[k].wdata;
         #1;
         check($sformatf("tbl%0d_req_ready", k), 32'(req_ready), 32'd1);
         next();
         check($sformatf("tbl%0d_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("tbl%0d_count", k), 32'(rsp_count), 32'd1);
         check($sformatf("tbl%0d_rdata", k), rsp_rdata, vecs[k].exp_rdata);
         check($sformatf("tbl%0d_err", k),   32'(rsp_err), 32'(vecs[k].exp_err));
      end
      req_valid = 1'b0;
      next();
      check("tbl_drain_count", 32'(rsp_count), 32'd0);
      check("tbl_drain_rdata", rsp_rdata, 32'd0);

      // ---- backpressure: three reads with rsp_ready low ----
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd5;
      #1 check("bp_ready0", 32'(req_ready), 32'd1);
      next();
      req_addr = 16'd6;
      #1 check("bp_ready1", 32'(req_ready), 32'd1);
      next();
      req_addr = 16'd7;
      #1 check("bp_ready2", 32'(req_ready), 32'd0);
      check("bp_count2", 32'(rsp_count), 32'd2);
      next();
      check("bp_hold_count", 32'(rsp_count), 32'd2);
      check("bp_hold_head",  rsp_rdata, 32'h105);
      rsp_ready = 1'b1;
      #1 check("bp_ready_pop", 32'(req_ready), 32'd1);
      next();
      req_valid = 1'b0;
      check("bp_swap_count", 32'(rsp_count), 32'd2);
      check("bp_swap_head",  rsp_rdata, 32'h106);
      next();
      check("bp_tail_count", 32'(rsp_count), 32'd1);
      check("bp_tail_head",  rsp_rdata, 32'h107);
      next();
      check("bp_empty", 32'(rsp_valid), 32'd0);

      // ---- reset in the middle of a full buffer ----
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'd9;
      req_wdata = 32'h0000AAAA;
      next();
      req_we = 1'b0;
      next();
      req_valid = 1'b0;
      check("mid_full_count", 32'(rsp_count), 32'd2);
      check("mid_full_head",  32'(rsp_err), 32'd0);
      #1 resetn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_count", 32'(rsp_count), 32'd0);
      check("mid_rst_rdata", rsp_rdata, 32'd0);
      @(posedge i_clk);
      #2 resetn = 1'b1;
      next();
      check("mid_post_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'd9;
      next();
      check("mid_read9_valid", 32'(rsp_valid), 32'd1);
      check("mid_read9_rdata", rsp_rdata, 32'd0);
      req_addr = 16'd5;
      next();
      req_valid = 1'b0;
      check("mid_read5_rdata", rsp_rdata, 32'd0);
      next();
      check("mid_drain_count", 32'(rsp_count), 32'd0);

      // ---- randomized valid/ready against a scoreboard ----
      for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
      accepted = 0;
      cycles   = 0;
      while (accepted < 1000 && cycles < 20000) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 16'($urandom_range(0, 17));
         req_wdata = $urandom;
         rsp_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_ready = (sbq.size() < 2) || rsp_ready;
         check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
         check("rnd_count", 32'(rsp_count), 32'(sbq.size()));
         check("rnd_valid", 32'(rsp_valid), 32'(sbq.size() != 0));
         if (sbq.size() != 0) begin
            check("rnd_rdata", rsp_rdata, sbq[0].rdata);
            check("rnd_err",   32'(rsp_err), 32'(sbq[0].err));
            if (rsp_ready) void'(sbq.pop_front());
         end
         if (req_valid && exp_ready) begin
            r.err   = (req_addr >= 16'd16);
            r.rdata = (!req_we && !r.err) ? mregs[req_addr[3:0]] : 32'h0;
            if (req_we && !r.err) mregs[req_addr[3:0]] = req_wdata;
            sbq.push_back(r);
            accepted++;
         end
         @(posedge i_clk);
         #1;
         cycles++;
      end
      check("rnd_accepted", 32'(accepted), 32'd1000);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 4 && sbq.size() != 0; n++) begin
         #1;
         check("drain_valid", 32'(rsp_valid), 32'd1);
         check("drain_rdata", rsp_rdata, sbq[0].rdata);
         check("drain_err",   32'(rsp_err), 32'(sbq[0].err));
         void'(sbq.pop_front());
         next();
      end
      check("drain_left", 32'(sbq.size()), 32'd0);
      check("drain_count", 32'(rsp_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_pal_rsp.md
# pipe_pal_rsp

Responder end of the pipe_pal register-access pipe. Accepts single-beat read/write requests from an initiator over a valid/ready request channel, services them against an internal bank of DEPTH registers, and returns one in-order response per request over a valid/ready response channel. A 2-entry response buffer decouples initiator backpressure from request acceptance. Sits on the slave side of any pipe_pal initiator.

## Interface
- W_DATA, 32, data width of registers, write data and read data
- W_ADDR, 16, request address width (word index, not byte address)
- DEPTH, 16, number of implemented registers; legal addresses 0..DEPTH-1 (DEPTH ≤ 2**W_ADDR)

- i_clk  input  1  single clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  W_ADDR  register index
- req_wdata  input  W_DATA  write data (ignored for reads)
- rsp_valid  output  1  response at buffer head is valid
- rsp_ready  input  1  initiator consumes the response
- rsp_rdata  output  W_DATA  read data; 0 for writes and errors
- rsp_err  output  1  1 = address ≥ DEPTH
- rsp_count  output  2  responses currently buffered (0..2)

## Operation
- Request accepted on a rising edge where req_valid && req_ready; response popped where rsp_valid && rsp_ready.
- req_ready = (rsp_count < 2) || rsp_ready (combinational; a full buffer accepts when the head pops in the same cycle).
- Accepted write, addr < DEPTH: register[addr] ← req_wdata at that edge; response {rdata=0, err=0}.
- Accepted read, addr < DEPTH: response {rdata=register[addr] as held before the edge, err=0}.
- Accepted request, addr ≥ DEPTH: no register changes; response {rdata=0, err=1}.
- Responses are strictly in acceptance order; exactly one per accepted request; none dropped or duplicated.
- Response buffer: 2-entry FIFO, write/read pointers wrap modulo 2; push and pop in the same cycle leave rsp_count unchanged (at 0 a push and no pop is possible, as rsp_valid=0).
- rsp_valid = (rsp_count != 0); rsp_rdata/rsp_err show the head entry, driven to 0 when empty.
- Request inputs are sampled only on acceptance; changes while req_ready=0 have no effect.

## Timing
- Reset (resetn low, asynchronous): all registers = 0, buffer emptied, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_count=0; req_ready=1 once reset is released (it follows from rsp_count=0).
- Reset asserted mid-operation: buffered responses discarded, no response for them after release; a write accepted on the same edge as reset assertion has no effect.
- Latency: request accepted at edge N → response visible (rsp_valid=1) after edge N, i.e. in cycle N+1, if the buffer was empty; otherwise behind earlier responses.
- Read-after-write: a write accepted at edge N is seen by a read accepted at edge N+1 or later.
- Sustained throughput: one request per cycle with rsp_ready held 1; with rsp_ready=0 at most 2 requests accepted, then req_ready=0.
- No combinational path from req_* to rsp_*; the only combinational path is rsp_ready → req_ready.

## Test plan
- Reset then write addr 3 = 0xDEADBEEF, read addr 3, rsp_ready=1 → responses {0,err 0} then {0xDEADBEEF, err 0}, each 1 cycle after acceptance; rsp_count never exceeds 1.
- Back-to-back reads of addrs 0..15 after writing 0x100+i to each, rsp_ready=1 → 16 responses in order with rdata 0x100..0x10F, req_ready constant 1.
- rsp_ready=0, issue 3 reads → first 2 accepted, req_ready=0, rsp_count=2; raise rsp_ready → third accepted on the same edge as the first pop, responses in order.
- Read addr 16 and write addr 0xFFFF with DEPTH=16 → both {rdata 0, err 1}; subsequent reads of addrs 0..15 unchanged.
- Fill buffer (2 responses pending), assert resetn low for 1 cycle → rsp_valid=0, rsp_count=0 immediately; read of a previously written address returns 0.
- Randomized valid/ready toggling, 1000 requests, against a scoreboard model → every response matches, no loss, ordering preserved.
